// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick from vsync, serve countdown, goal detection and scoring.
// Decisions are taken once per frame; the ball block follows center/freeze/serve.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int LEFT_GOAL    = 20,
  parameter int RIGHT_GOAL   = 619,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               start,
  input  logic               pause,
  input  logic [9:0]         ball_x,
  output logic               ball_center,
  output logic               ball_freeze,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic [2:0]         state,
  output logic               frame_tick
);

  localparam int CNT_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [9:0]         LEFT_X     = 10'(LEFT_GOAL);
  localparam logic [9:0]         RIGHT_X    = 10'(RIGHT_GOAL);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   serve_cnt;
  logic               vsync_meta, vsync_sync, vsync_prev;
  logic               start_meta, start_sync, start_prev;
  logic               start_pe;
  logic [SCORE_W-1:0] point_score;
  logic [SCORE_W-1:0] point_next;
  logic               serve_now;

  // Sync flops idle high so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_meta <= 1'b1;
      vsync_sync <= 1'b1;
      vsync_prev <= 1'b1;
      start_meta <= 1'b1;
      start_sync <= 1'b1;
      start_prev <= 1'b1;
      frame_tick <= 1'b0;
      start_pe   <= 1'b0;
    end else begin
      vsync_meta <= vsync;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
      frame_tick <= vsync_prev & ~vsync_sync;
      start_pe   <= ~start_prev & start_sync;
    end
  end

  // serve_dir doubles as the record of who just scored while in POINT.
  always_comb begin
    point_score = serve_dir ? score_p1 : score_p2;
    point_next  = (point_score == SCORE_MAX) ? SCORE_MAX : point_score + 1'b1;
  end

  assign serve_now = (state_reg == SERVE_WAIT) && frame_tick && !pause && (serve_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      serve_cnt <= '0;
      serve_dir <= 1'b1;
      score_p1  <= '0;
      score_p2  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_pe) begin
            serve_cnt <= SERVE_LOAD;
            score_p1  <= '0;
            score_p2  <= '0;
            state_reg <= SERVE_WAIT;
          end
        end
        SERVE_WAIT: begin
          if (frame_tick && !pause) begin
            if (serve_cnt == '0) state_reg <= PLAY;
            else                 serve_cnt <= serve_cnt - 1'b1;
          end
        end
        PLAY: begin
          if (frame_tick && !pause) begin
            if (ball_x <= LEFT_X) begin
              serve_dir <= 1'b0;
              state_reg <= POINT;
            end else if (ball_x >= RIGHT_X) begin
              serve_dir <= 1'b1;
              state_reg <= POINT;
            end
          end
        end
        POINT: begin
          if (serve_dir) score_p1 <= point_next;
          else           score_p2 <= point_next;
          serve_cnt <= SERVE_LOAD;
          state_reg <= (point_next == WIN_VAL) ? GAME_OVER : SERVE_WAIT;
        end
        GAME_OVER: begin
          if (start_pe) begin
            score_p1  <= '0;
            score_p2  <= '0;
            serve_cnt <= SERVE_LOAD;
            serve_dir <= 1'b1;
            state_reg <= SERVE_WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign state       = state_reg;
  assign ball_center = (state_reg == IDLE) || (state_reg == SERVE_WAIT) ||
                       (state_reg == POINT) || (state_reg == GAME_OVER);
  assign ball_freeze = (state_reg == PLAY) && pause;
  assign game_over   = (state_reg == GAME_OVER);
  assign ball_serve  = serve_now;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: per-cycle comparison against a frame-level game model,
// plus directed scenarios with literal expectations.
module tb_pong_game_ctrl;

  localparam int SF   = 3;
  localparam int WIN  = 7;
  localparam int LG   = 20;
  localparam int RG   = 619;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vsync = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [9:0]    ball_x = 10'd320;
  logic          ball_center, ball_freeze, ball_serve, serve_dir;
  logic [SW-1:0] score_p1, score_p2;
  logic          game_over, frame_tick;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl #(
    .SERVE_FRAMES(SF), .WIN_SCORE(WIN), .LEFT_GOAL(LG), .RIGHT_GOAL(RG), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .start(start), .pause(pause),
    .ball_x(ball_x), .ball_center(ball_center), .ball_freeze(ball_freeze),
    .ball_serve(ball_serve), .serve_dir(serve_dir), .score_p1(score_p1),
    .score_p2(score_p2), .game_over(game_over), .state(state), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Game model: inputs seen 3 clocks late (2-flop sync + edge detect), one decision per edge.
  int       m_state = 0;
  int       m_p1 = 0, m_p2 = 0, m_cnt = 0;
  logic     m_dir = 1'b1, m_ft = 1'b0, m_spe = 1'b0;
  logic [2:0] vh = 3'b111, sh = 3'b111;

  function automatic int bump(input int v);
    return (v >= (1 << SW) - 1) ? (1 << SW) - 1 : v + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= 0; m_p1 <= 0; m_p2 <= 0; m_cnt <= 0; m_dir <= 1'b1;
      m_ft <= 1'b0; m_spe <= 1'b0; vh <= 3'b111; sh <= 3'b111;
    end else begin
      case (m_state)
        0: if (m_spe) begin m_state <= 1; m_cnt <= SF; m_p1 <= 0; m_p2 <= 0; end
        1: if (m_ft && !pause) begin
             if (m_cnt == 0) m_state <= 2;
             else            m_cnt <= m_cnt - 1;
           end
        2: if (m_ft && !pause) begin
             if (int'(ball_x) <= LG)      begin m_dir <= 1'b0; m_state <= 3; end
             else if (int'(ball_x) >= RG) begin m_dir <= 1'b1; m_state <= 3; end
           end
        3: begin
             if (m_dir) begin
               m_p1 <= bump(m_p1);
               m_state <= (bump(m_p1) == WIN) ? 4 : 1;
             end else begin
               m_p2 <= bump(m_p2);
               m_state <= (bump(m_p2) == WIN) ? 4 : 1;
             end
             m_cnt <= SF;
           end
        4: if (m_spe) begin
             m_state <= 1; m_p1 <= 0; m_p2 <= 0; m_cnt <= SF; m_dir <= 1'b1;
           end
        default: m_state <= 0;
      endcase
      m_ft  <= vh[2] & ~vh[1];
      m_spe <= ~sh[2] & sh[1];
      vh <= {vh[1:0], vsync};
      sh <= {sh[1:0], start};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("state",       int'(state),       m_state);
    check("score_p1",    int'(score_p1),    m_p1);
    check("score_p2",    int'(score_p2),    m_p2);
    check("serve_dir",   int'(serve_dir),   int'(m_dir));
    check("frame_tick",  int'(frame_tick),  int'(m_ft));
    check("ball_center", int'(ball_center), int'(m_state != 2));
    check("ball_freeze", int'(ball_freeze), int'(m_state == 2 && pause));
    check("ball_serve",  int'(ball_serve),  int'(m_state == 1 && m_ft && !pause && m_cnt == 0));
    check("game_over",   int'(game_over),   int'(m_state == 4));
  end

  int serve_total = 0, serve_on_tick = 0, ft_total = 0;
  always @(negedge clk) begin
    if (ball_serve) serve_total <= serve_total + 1;
    if (ball_serve && frame_tick) serve_on_tick <= serve_on_tick + 1;
    if (frame_tick) ft_total <= ft_total + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic frame();
    vsync = 1'b0; tick(2); vsync = 1'b1; tick(6);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic start_pulse();
    start = 1'b1; tick(4); start = 1'b0; tick(4);
  endtask

  int ft0, sv0;

  initial begin
    tick(4);
    check("rst_state", int'(state), 0);
    check("rst_p1", int'(score_p1), 0);
    check("rst_dir", int'(serve_dir), 1);
    check("rst_tick", int'(frame_tick), 0);
    reset_n = 1'b1;
    tick(4);

    start_pulse();
    check("t1_wait", int'(state), 1);
    frames(3);
    check("t1_still_wait", int'(state), 1);
    frame();
    check("t1_play", int'(state), 2);
    check("t1_center", int'(ball_center), 0);
    check("t1_serve_on_tick", serve_on_tick, 1);
    $display("step 1: serve after %0d frames, state=%0d", SF + 1, state);

    ball_x = 10'd15;
    frame();
    check("t2_state", int'(state), 1);
    check("t2_p2", int'(score_p2), 1);
    check("t2_dir", int'(serve_dir), 0);
    check("t2_center", int'(ball_center), 1);
    $display("step 2: left goal, score_p2=%0d", score_p2);
    ball_x = 10'd320;
    frames(4);
    check("t2_replay", int'(state), 2);

    start_pulse();
    check("t4_start_in_play", int'(state), 2);

    for (int i = 0; i < 7; i++) begin
      ball_x = 10'd620;
      frame();
      $display("step 3: right goal %0d, score_p1=%0d state=%0d", i + 1, score_p1, state);
      if (i < 6) begin
        ball_x = 10'd320;
        frames(4);
      end
    end
    check("t3_state", int'(state), 4);
    check("t3_over", int'(game_over), 1);
    check("t3_p1", int'(score_p1), 7);
    frames(2);
    check("t3_p1_hold", int'(score_p1), 7);

    start_pulse();
    check("t4_state", int'(state), 1);
    check("t4_p1", int'(score_p1), 0);
    check("t4_p2", int'(score_p2), 0);
    $display("step 4: restart from game over, state=%0d", state);

    pause = 1'b1;
    frames(10);
    pause = 1'b0;
    frames(3);
    check("t5_cnt_frozen", int'(state), 1);
    frame();
    check("t5_served", int'(state), 2);
    ball_x = 10'd0;
    pause = 1'b1;
    frames(2);
    check("t5_freeze", int'(ball_freeze), 1);
    check("t5_no_score", int'(score_p2), 0);
    pause = 1'b0;
    frame();
    check("t5_scored", int'(score_p2), 1);
    check("t5_state", int'(state), 1);
    $display("step 5: pause hold, score_p2=%0d", score_p2);

    ball_x = 10'd320;
    frames(4);
    check("t6_play", int'(state), 2);
    check("serve_count", serve_total, 10);
    check("serve_coincident", serve_on_tick, serve_total);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t6_state", int'(state), 0);
    check("t6_p2", int'(score_p2), 0);
    tick(3);
    reset_n = 1'b1;
    ft0 = ft_total;
    sv0 = serve_total;
    tick(10);
    check("t6_no_tick", ft_total, ft0);
    check("t6_no_serve", serve_total, sv0);
    check("t6_idle", int'(state), 0);
    $display("step 6: async reset mid-play, state=%0d", state);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
